q_meter: RTL and testbench
==========================

Name: q_meter

Overview:
- Measurement front stage directly upstream of the secant current controller.
- Watches the i_ref the controller drives; on every new i_ref, waits a settling window, then averages 2^LOG2_AVG ADC charge samples.
- Presents the average as q_measured with a one-cycle ready strobe, which the controller consumes as its ready / q_measured inputs.
- Keeps re-measuring continuously while i_ref is unchanged.

Parameters:
- BUS_WIDTH, 10: width of i_ref and q_measured.
- ADC_WIDTH, 10: width of adc_data; must be >= BUS_WIDTH.
- LOG2_AVG, 2: log2 of the number of samples averaged per measurement (N = 2^LOG2_AVG, 1..64).
- SETTLE_CYCLES, 16: clk cycles waited after an i_ref change before samples are accepted (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low.
- enable  in  1  block enable; low forces IDLE.
- i_ref  in  BUS_WIDTH  current reference from the secant controller; monitored for change.
- adc_data  in  ADC_WIDTH  unsigned charge sample.
- adc_valid  in  1  adc_data is valid this cycle; sample accepted only in ACCUM.
- q_measured  out  BUS_WIDTH  averaged charge, held between updates.
- ready  out  1  one-cycle strobe: q_measured has just been updated.
- busy  out  1  high in SETTLE or ACCUM.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - q_measured = 0, ready = 0, busy = 0.
  - Accumulator, sample count, settle count and i_ref_q (registered copy of i_ref) all 0.
  - Reset mid-measurement discards all partial data.
- State machine: IDLE, SETTLE, ACCUM, DONE.
  - IDLE: on enable = 1, load i_ref_q <= i_ref, clear settle count, go to SETTLE.
  - SETTLE: increment settle count each cycle; after SETTLE_CYCLES cycles in SETTLE, clear accumulator and sample count, go to ACCUM. adc_valid ignored.
  - ACCUM: on adc_valid, acc += adc_data and count += 1. When the N-th sample is accepted, go to DONE.
  - DONE (exactly one cycle): ready = 1 and q_measured updates in this same cycle (registered on the edge entering DONE). Then clear accumulator and count, return to ACCUM (continuous mode, no re-settle).
- Restart rule: in SETTLE, ACCUM or DONE, if enable = 1 and i_ref != i_ref_q:
  - i_ref_q <= i_ref, settle count cleared, next state SETTLE.
  - Partial accumulation is dropped.
  - This has priority over N-th-sample completion; no ready is issued for that measurement.
- Arithmetic:
  - Accumulator is ADC_WIDTH+LOG2_AVG bits, unsigned, cannot overflow.
  - mean = acc >> LOG2_AVG (truncating).
  - q_measured = mean[ADC_WIDTH-1 -: BUS_WIDTH], i.e. the LSBs are dropped when ADC_WIDTH > BUS_WIDTH.
- enable low in any state: next state IDLE, ready = 0, busy = 0, q_measured held.
- ready is never high on two consecutive cycles.
- Latency, with adc_valid held high, from the i_ref change edge:
  - SETTLE_CYCLES cycles in SETTLE, plus N cycles in ACCUM, then ready.
  - ready rises at edge change + SETTLE_CYCLES + N + 1.
- Continuous mode: with adc_valid held high, ready recurs every N+1 cycles.

Optional Feature:
- Macro: Q_METER_OFFSET_EN.
- Defined:
  - Adds input port q_offset (in, BUS_WIDTH), sampled only in DONE.
  - q_measured = truncated mean - q_offset, saturating at 0 (never wraps).
- Undefined: port absent; q_measured is the truncated mean.

Test Plan:
- Reset and defaults: rst_n low with adc_valid toggling -> q_measured = 0, ready = 0, busy = 0. Release with enable = 0 -> stays IDLE, no ready.
- Basic measurement (SETTLE_CYCLES = 4, LOG2_AVG = 2):
  - enable = 1, i_ref = 100, adc_data = 200/204/208/212 with adc_valid high.
  - Expect q_measured = 206 with a single ready pulse at edge 4 + 4 + 1 after enable.
  - Next ready follows 5 cycles later.
- Restart: change i_ref 100 -> 300 after the 3rd accepted sample -> no ready for the aborted window, busy stays high, full settle re-run. Also check i_ref change on the same cycle as the 4th sample -> no ready.
- Gapped valid: adc_valid asserted every 3rd cycle during ACCUM -> only valid cycles counted, ready after the 4th valid sample, samples offered during SETTLE ignored.
- Width/saturation:
  - ADC_WIDTH = 12, BUS_WIDTH = 10, all samples 4095 -> q_measured = 1023, no overflow.
  - With Q_METER_OFFSET_EN, mean 5 and q_offset 9 -> q_measured = 0.
  - With Q_METER_OFFSET_EN, mean 206 and q_offset 6 -> q_measured = 200.
- enable drop mid-ACCUM -> IDLE next cycle, q_measured unchanged. Re-enable -> full SETTLE before the next ready.

Source files
------------

// File: rtl/q_meter.sv
// rtl/q_meter.sv - settle-then-average charge meter feeding the secant current controller
// Optional macro Q_METER_OFFSET_EN adds a q_offset port subtracted (saturating at 0) from the mean.
module q_meter #(
    parameter int BUS_WIDTH     = 10,
    parameter int ADC_WIDTH     = 10,
    parameter int LOG2_AVG      = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
`ifdef Q_METER_OFFSET_EN
    input  logic [BUS_WIDTH-1:0] q_offset,
`endif
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy
);

    localparam int ACC_W = ADC_WIDTH + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

    state_t               state, state_next;
    logic [BUS_WIDTH-1:0] i_ref_q, i_ref_q_next;
    logic [SET_W-1:0]     settle_cnt, settle_cnt_next;
    logic [ACC_W-1:0]     acc, acc_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BUS_WIDTH-1:0] q_next;
    logic                 ready_next, busy_next;

    logic [ACC_W-1:0]     acc_sum;
    logic [ADC_WIDTH-1:0] mean;
    logic [BUS_WIDTH-1:0] mean_bus;
    logic [BUS_WIDTH-1:0] q_calc;
    logic                 restart;

    assign acc_sum  = acc + ACC_W'(adc_data);
    assign mean     = acc_sum[ACC_W-1:LOG2_AVG];
    assign mean_bus = mean[ADC_WIDTH-1 -: BUS_WIDTH];

`ifdef Q_METER_OFFSET_EN
    assign q_calc = (mean_bus > q_offset) ? (mean_bus - q_offset) : '0;
`else
    assign q_calc = mean_bus;
`endif

    assign restart = (state != IDLE) && (i_ref != i_ref_q);

    always_comb begin
        state_next      = state;
        i_ref_q_next    = i_ref_q;
        settle_cnt_next = settle_cnt;
        acc_next        = acc;
        cnt_next        = cnt;
        q_next          = q_measured;
        if (!enable) begin
            state_next = IDLE;
        end else if (restart) begin
            // a new reference invalidates any partial window, even a complete one
            i_ref_q_next    = i_ref;
            settle_cnt_next = '0;
            acc_next        = '0;
            cnt_next        = '0;
            state_next      = SETTLE;
        end else begin
            case (state)
                IDLE: begin
                    i_ref_q_next    = i_ref;
                    settle_cnt_next = '0;
                    state_next      = SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = ACCUM;
                    end else begin
                        settle_cnt_next = settle_cnt + SET_W'(1);
                    end
                end
                ACCUM: begin
                    if (adc_valid) begin
                        acc_next = acc_sum;
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            q_next     = q_calc;
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = ACCUM;
                end
                default: state_next = IDLE;
            endcase
        end
        ready_next = (state_next == DONE);
        busy_next  = (state_next == SETTLE) || (state_next == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            i_ref_q    <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            cnt        <= '0;
            q_measured <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            i_ref_q    <= i_ref_q_next;
            settle_cnt <= settle_cnt_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            q_measured <= q_next;
            ready      <= ready_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_q_meter.sv
// tb/tb_q_meter.sv - self-checking bench for q_meter (10-bit and 12-to-10-bit instances)
module tb_q_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        adc_valid = 1'b0;
    logic [9:0]  i_ref = '0;
    logic [9:0]  adc_data = '0;
    logic [11:0] adc_data_b = 12'hFFF;
    logic [9:0]  q_offset = '0;
    logic [9:0]  q_offset_b = '0;
    logic [9:0]  q_measured, q_b;
    logic        ready, busy, ready_b, busy_b;

    always #5 clk = ~clk;

    q_meter #(.BUS_WIDTH(10), .ADC_WIDTH(10), .LOG2_AVG(2), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_ref(i_ref),
        .adc_data(adc_data), .adc_valid(adc_valid),
`ifdef Q_METER_OFFSET_EN
        .q_offset(q_offset),
`endif
        .q_measured(q_measured), .ready(ready), .busy(busy)
    );

    q_meter #(.BUS_WIDTH(10), .ADC_WIDTH(12), .LOG2_AVG(2), .SETTLE_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_ref(i_ref),
        .adc_data(adc_data_b), .adc_valid(adc_valid),
`ifdef Q_METER_OFFSET_EN
        .q_offset(q_offset_b),
`endif
        .q_measured(q_b), .ready(ready_b), .busy(busy_b)
    );

    typedef struct {
        int         cyc;
        logic [9:0] q;
    } exp_t;

    typedef struct {
        logic [9:0] iref;
        int         s[4];
        logic [9:0] exp;
    } vec_t;

    exp_t       sb[$];
    vec_t       vt[5];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         prev_ready = 1'b0;
    logic [9:0] last_q = '0;
    int         fives[4];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon();
        exp_t e;
        if (!rst_n) begin
            prev_ready = 1'b0;
            return;
        end
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
            check(1'b0, "ready_missing", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (ready) begin
            check(!prev_ready, "ready_double", 1, 0);
            if (sb.size() == 0) begin
                check(1'b0, "ready_unexpected", cyc, -1);
            end else begin
                e = sb.pop_front();
                check(e.cyc == cyc, "ready_cycle", cyc, e.cyc);
                check(q_measured == e.q, "q_measured", int'(q_measured), int'(e.q));
            end
            check(ready_b && q_b == 10'd1023, "wide_q", int'(q_b), 1023);
        end else if (ready_b) begin
            check(1'b0, "wide_ready_unexpected", 1, 0);
        end
        prev_ready = ready;
    endtask

    // new reference driven just after an edge; leaves the bench just after the SETTLE->ACCUM edge
    task automatic start(input logic [9:0] iref);
        i_ref     = iref;
        enable    = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 10'd1023;
        repeat (5) tick();
    endtask

    task automatic window(input int s[4], input int gap, input logic [9:0] exp);
        for (int j = 0; j < 4; j++) begin
            repeat (gap) begin
                adc_valid = 1'b0;
                adc_data  = 10'd1023;
                tick();
            end
            adc_valid = 1'b1;
            adc_data  = 10'(s[j]);
            if (j == 3) begin
                sb.push_back('{cyc + 1, exp});
                last_q = exp;
            end
            tick();
        end
    endtask

    initial begin
        vt[0] = '{10'd100, '{200, 204, 208, 212}, 10'd206};
        vt[1] = '{10'd101, '{0, 0, 0, 0}, 10'd0};
        vt[2] = '{10'd102, '{1023, 1023, 1023, 1023}, 10'd1023};
        vt[3] = '{10'd103, '{1, 2, 3, 3}, 10'd2};
        vt[4] = '{10'd104, '{40, 44, 48, 52}, 10'd46};
        fives = '{5, 5, 5, 5};

        fork
            forever begin @(posedge clk); cyc++; end
            forever begin @(negedge clk); mon(); end
        join_none

        for (int i = 0; i < 4; i++) begin
            adc_valid = ~adc_valid;
            adc_data  = 10'd500;
            @(negedge clk);
            check(q_measured == 10'd0, "reset_q", int'(q_measured), 0);
            check(ready == 1'b0, "reset_ready", int'(ready), 0);
            check(busy == 1'b0, "reset_busy", int'(busy), 0);
        end
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check(busy == 1'b0 && ready == 1'b0, "idle_disabled", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            start(vt[i].iref);
            window(vt[i].s, 0, vt[i].exp);
            adc_valid = 1'b1;
            adc_data  = 10'd1023;
            tick();
            window(vt[i].s, 0, vt[i].exp);
        end

        // restart after three accepted samples; the restart edge also offers a valid sample
        start(10'd310);
        for (int j = 0; j < 3; j++) begin
            adc_data = 10'd200;
            tick();
        end
        i_ref     = 10'd320;
        adc_valid = 1'b1;
        adc_data  = 10'd1023;
        tick();
        check(busy == 1'b1, "restart_busy", int'(busy), 1);
        repeat (4) tick();
        window(vt[0].s, 0, vt[0].exp);

        // reference change on the same edge as the 4th sample
        adc_valid = 1'b1;
        adc_data  = 10'd1023;
        tick();
        for (int j = 0; j < 3; j++) begin
            adc_data = 10'd100;
            tick();
        end
        adc_data = 10'd100;
        i_ref    = 10'd330;
        tick();
        check(busy == 1'b1, "restart4_busy", int'(busy), 1);
        repeat (4) tick();
        window(vt[3].s, 0, vt[3].exp);

        // valid every third cycle, with valid samples offered during SETTLE
        start(10'd600);
        window(vt[4].s, 2, vt[4].exp);

        // enable drop mid-ACCUM
        start(10'd700);
        adc_data = 10'd300;
        tick();
        tick();
        enable = 1'b0;
        tick();
        check(busy == 1'b0, "disable_busy", int'(busy), 0);
        check(ready == 1'b0, "disable_ready", int'(ready), 0);
        check(q_measured == last_q, "disable_q_held", int'(q_measured), int'(last_q));
        repeat (3) tick();
        check(q_measured == last_q, "idle_q_held", int'(q_measured), int'(last_q));
        enable    = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 10'd1023;
        repeat (5) tick();
        window(vt[0].s, 0, vt[0].exp);

`ifdef Q_METER_OFFSET_EN
        q_offset = 10'd6;
        start(10'd800);
        window(vt[0].s, 0, 10'd200);
        q_offset = 10'd9;
        start(10'd810);
        window(fives, 0, 10'd0);
        q_offset = 10'd0;
`endif

        adc_valid = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        check(sb.size() == 0, "sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
